// File: rtl/shift_frame_arbiter.sv
// Round-robin arbiter that serialises one of two WIDTH-bit frames MSB-first onto a
// 74HC595-style chain (data / shift clock / latch clock), then acks the requester.
// Optional SKIP_UNCHANGED_EN: a granted frame equal to the last latched frame is acked
// at once, without shifting or latching.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for a request; the grant and data capture happen here
// S_SHIFT_LO | shift_clk low, current MSB presented on data_out (CLK_DIV cycles)
// S_SHIFT_HI | shift_clk high, data_out held (CLK_DIV cycles), shift on exit
// S_LATCH    | latch_clk high, data_out low (CLK_DIV cycles)
// S_DONE     | one-cycle ack to the granted requester

module shift_frame_arbiter #(
   parameter int WIDTH   = 16,
   parameter int CLK_DIV = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             ack0,
   output logic             ack1,
   output logic             busy,
   output logic             data_out,
   output logic             shift_clk,
   output logic             latch_clk
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SHIFT_LO = 3'd1,
      S_SHIFT_HI = 3'd2,
      S_LATCH    = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic             grant_q, grant_d;
   logic             last_grant_q, last_grant_d;

   logic             any_req;
   logic             pick;
   logic [WIDTH-1:0] pick_data;
   logic             div_tc;
   logic             skip_hit;

   logic             ack0_d, ack1_d, busy_d, data_out_d, shift_clk_d, latch_clk_d;

   // On a tie the requester that did not win last time is served.
   always_comb begin
      any_req   = req0 | req1;
      pick      = (req0 & req1) ? ~last_grant_q : req1;
      pick_data = pick ? data1 : data0;
      div_tc    = (div_q == '0);
   end

`ifdef SKIP_UNCHANGED_EN
   logic [WIDTH-1:0] frame_q;
   logic [WIDTH-1:0] last_frame_q;
   logic             last_valid_q;

   assign skip_hit = last_valid_q && (pick_data == last_frame_q);

   // frame_q keeps the whole frame because sreg is consumed while shifting.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_q      <= '0;
         last_frame_q <= '0;
         last_valid_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && any_req)
            frame_q <= pick_data;
         if (state_q == S_LATCH && div_tc) begin
            last_frame_q <= frame_q;
            last_valid_q <= 1'b1;
         end
      end
   end
`else
   assign skip_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         sreg_q       <= '0;
         div_q        <= '0;
         bit_q        <= '0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         busy         <= 1'b0;
         data_out     <= 1'b0;
         shift_clk    <= 1'b0;
         latch_clk    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         div_q        <= div_d;
         bit_q        <= bit_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         ack0         <= ack0_d;
         ack1         <= ack1_d;
         busy         <= busy_d;
         data_out     <= data_out_d;
         shift_clk    <= shift_clk_d;
         latch_clk    <= latch_clk_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      div_d        = div_q;
      bit_d        = bit_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;

      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               grant_d = pick;
               sreg_d  = pick_data;
               bit_d   = '0;
               div_d   = DIV_LOAD;
               state_d = skip_hit ? S_DONE : S_SHIFT_LO;
            end
         end

         S_SHIFT_LO: begin
            if (div_tc) begin
               div_d   = DIV_LOAD;
               state_d = S_SHIFT_HI;
            end else begin
               div_d = div_q - DIV_W'(1);
            end
         end

         S_SHIFT_HI: begin
            if (div_tc) begin
               sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
               div_d  = DIV_LOAD;
               if (bit_q == BIT_LAST) begin
                  state_d = S_LATCH;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  state_d = S_SHIFT_LO;
               end
            end else begin
               div_d = div_q - DIV_W'(1);
            end
         end

         S_LATCH: begin
            if (div_tc)
               state_d = S_DONE;
            else
               div_d = div_q - DIV_W'(1);
         end

         S_DONE: begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the pins line up with the state register.
   always_comb begin
      busy_d      = (state_d != S_IDLE);
      shift_clk_d = (state_d == S_SHIFT_HI);
      latch_clk_d = (state_d == S_LATCH);
      data_out_d  = ((state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI)) ? sreg_d[WIDTH-1] : 1'b0;
      ack0_d      = (state_d == S_DONE) & ~grant_d;
      ack1_d      = (state_d == S_DONE) &  grant_d;
   end

endmodule
